// File: rtl/apb_sched_pkg.sv
// Shared constants for the APB transaction scheduler: FSM state encodings and a
// width helper used to size pointers and counters.
package apb_sched_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  // Never returns less than 1 so single-value ranges still get a legal vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting index strictly
// after ptr, wrapping; ptr itself is searched last.
module rr_arbiter
  import apb_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_any && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        grant_idx          = PW'(idx);
        grant_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_txn_scheduler.sv
// Shares one APB master port between NREQ requesters: round-robin accept, one
// SETUP/ACCESS transfer at a time with optional wait-state timeout, routed response.
module apb_txn_scheduler
  import apb_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ-1:0]    req_write_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]      rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               psel_o,
  output logic               penable_o,
  output logic               pwrite_o,
  output logic [AW-1:0]      paddr_o,
  output logic [DW-1:0]      pwdata_o,
  input  logic [DW-1:0]      prdata_i,
  input  logic               pready_i
);

  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(TIMEOUT + 1);

  logic [1:0]      state_reg, state_next;
  logic [PW-1:0]   ptr_reg, owner_reg;
  logic            write_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;
  logic [CW-1:0]   cnt_reg;
  logic [NREQ-1:0] rsp_valid_reg;
  logic [DW-1:0]   rsp_rdata_reg;
  logic            rsp_err_reg;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            timeout_hit;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr_i[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata_i[gi*DW +: DW];
    end
  endgenerate

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req       (req_valid_i),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A ready slave on the last allowed wait cycle still completes normally.
  assign timeout_hit = (TIMEOUT != 0) && !pready_i && (cnt_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accept is only offered while reset is released so nothing is acknowledged
  // that the registers cannot capture.
  always_comb begin
    psel_o      = (state_reg == SETUP) || (state_reg == ACCESS);
    penable_o   = (state_reg == ACCESS);
    req_ready_o = ((state_reg == IDLE) && !reset) ? grant : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg       <= PW'(NREQ - 1);
      owner_reg     <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cnt_reg       <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      if (state_reg == IDLE && grant_any) begin
        ptr_reg   <= grant_idx;
        owner_reg <= grant_idx;
        write_reg <= req_write_i[grant_idx];
        addr_reg  <= addr_arr[grant_idx];
        wdata_reg <= wdata_arr[grant_idx];
      end
      if (state_reg == SETUP) cnt_reg <= '0;
      if (state_reg == ACCESS) begin
        if (pready_i) begin
          rsp_valid_reg <= NREQ'(1) << owner_reg;
          rsp_rdata_reg <= write_reg ? '0 : prdata_i;
        end else if (timeout_hit) begin
          rsp_valid_reg <= NREQ'(1) << owner_reg;
          rsp_err_reg   <= 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign pwrite_o    = write_reg;
  assign paddr_o     = addr_reg;
  assign pwdata_o    = wdata_reg;

endmodule
